// File: rtl/spi_sck_engine.sv
// SPI SCK generator: programmable half-period divider, CPOL/CPHA modes and bit counting.
// Shift/sample strobes are already resolved for the mode, so the shift register needs no mode logic.
module spi_sck_engine #(
  parameter int DIV_WIDTH = 8,
  parameter int CNT_WIDTH = 6
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 en_i,
  input  logic                 start_i,
  input  logic                 cpol_i,
  input  logic                 cpha_i,
  input  logic [DIV_WIDTH-1:0] div_i,
  input  logic [CNT_WIDTH-1:0] nbits_i,
  output logic                 busy_o,
  output logic                 done_o,
  output logic                 sck_o,
  output logic                 lead_o,
  output logic                 trail_o,
  output logic                 shift_o,
  output logic                 sample_o,
  output logic [CNT_WIDTH-1:0] bit_cnt_o
);

  typedef enum logic {IDLE, ACTIVE} state_e;

  state_e               state_q, state_d;
  logic [DIV_WIDTH-1:0] div_q, div_d;
  logic [DIV_WIDTH-1:0] hc_q, hc_d;
  logic [CNT_WIDTH-1:0] nbits_q, nbits_d;
  logic [CNT_WIDTH-1:0] bit_cnt_q, bit_cnt_d;
  logic [CNT_WIDTH:0]   edge_q, edge_d;
  logic [CNT_WIDTH:0]   edge_nxt;
  logic [CNT_WIDTH:0]   last_edge;
  logic                 cpol_q, cpol_d, cpha_q, cpha_d;
  logic                 sck_q, sck_d, busy_q, busy_d, done_q, done_d;
  logic                 lead_q, lead_d, trail_q, trail_d;
  logic                 shift_q, shift_d, sample_q, sample_d;

  assign edge_nxt  = edge_q + (CNT_WIDTH+1)'(1);
  assign last_edge = {nbits_q, 1'b0};

  // NOTE: every _d signal gets a default first so no path through this block can infer a latch.
  always_comb begin
    state_d   = state_q;
    div_d     = div_q;
    hc_d      = hc_q;
    nbits_d   = nbits_q;
    bit_cnt_d = bit_cnt_q;
    edge_d    = edge_q;
    cpol_d    = cpol_q;
    cpha_d    = cpha_q;
    sck_d     = sck_q;
    done_d    = 1'b0;
    lead_d    = 1'b0;
    trail_d   = 1'b0;
    shift_d   = 1'b0;
    sample_d  = 1'b0;

    case (state_q)
      IDLE: begin
        sck_d = cpol_i;
        if (start_i && en_i) begin
          div_d     = div_i;
          nbits_d   = nbits_i;
          cpol_d    = cpol_i;
          cpha_d    = cpha_i;
          hc_d      = div_i;
          edge_d    = '0;
          bit_cnt_d = '0;
          if (nbits_i == '0) begin
            done_d = 1'b1;
          end else begin
            state_d = ACTIVE;
            // With cpha=0 the first bit must be on MOSI before the first (sampling) edge.
            shift_d = ~cpha_i;
          end
        end
      end

      default: begin
        if (!en_i) begin
          state_d = IDLE;
          sck_d   = cpol_i;
        end else if (hc_q == '0) begin
          hc_d    = div_q;
          sck_d   = ~sck_q;
          edge_d  = edge_nxt;
          lead_d  = edge_nxt[0];
          trail_d = ~edge_nxt[0];
          if (cpha_q) begin
            shift_d  = lead_d;
            sample_d = trail_d;
          end else begin
            shift_d  = trail_d && (edge_nxt != last_edge);
            sample_d = lead_d;
          end
          bit_cnt_d = bit_cnt_q + CNT_WIDTH'(sample_d);
          if (edge_nxt == last_edge) begin
            state_d = IDLE;
            done_d  = 1'b1;
          end
        end else begin
          hc_d = hc_q - DIV_WIDTH'(1);
        end
      end
    endcase

    busy_d = (state_d == ACTIVE);
  end

  // NOTE: sequential state uses non-blocking assignments only, so every register samples pre-edge values.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q   <= IDLE;
      div_q     <= '0;
      hc_q      <= '0;
      nbits_q   <= '0;
      bit_cnt_q <= '0;
      edge_q    <= '0;
      cpol_q    <= 1'b0;
      cpha_q    <= 1'b0;
      sck_q     <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      lead_q    <= 1'b0;
      trail_q   <= 1'b0;
      shift_q   <= 1'b0;
      sample_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      div_q     <= div_d;
      hc_q      <= hc_d;
      nbits_q   <= nbits_d;
      bit_cnt_q <= bit_cnt_d;
      edge_q    <= edge_d;
      cpol_q    <= cpol_d;
      cpha_q    <= cpha_d;
      sck_q     <= sck_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      lead_q    <= lead_d;
      trail_q   <= trail_d;
      shift_q   <= shift_d;
      sample_q  <= sample_d;
    end
  end

  assign busy_o    = busy_q;
  assign done_o    = done_q;
  assign sck_o     = sck_q;
  assign lead_o    = lead_q;
  assign trail_o   = trail_q;
  assign shift_o   = shift_q;
  assign sample_o  = sample_q;
  assign bit_cnt_o = bit_cnt_q;

endmodule

// File: tb/tb_spi_sck_engine.sv
// Bench for spi_sck_engine: vector table, directed corner sequences and randomized transfers
// compared cycle by cycle against an edge-time model derived from the half-period arithmetic.
module tb_spi_sck_engine;

  logic       clk = 1'b0;
  logic       rst, en, start, cpol, cpha;
  logic [7:0] div;
  logic [5:0] nbits;
  logic       busy, done, sck, lead, trail, shift, sample;
  logic [5:0] bit_cnt;

  logic        start12;
  logic [11:0] div12;
  logic        busy12, done12, sck12, lead12, trail12, shift12, sample12;
  logic [5:0]  bit_cnt12;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  spi_sck_engine u_dut (
    .clk_i(clk), .rst_i(rst), .en_i(en), .start_i(start), .cpol_i(cpol), .cpha_i(cpha),
    .div_i(div), .nbits_i(nbits), .busy_o(busy), .done_o(done), .sck_o(sck),
    .lead_o(lead), .trail_o(trail), .shift_o(shift), .sample_o(sample), .bit_cnt_o(bit_cnt)
  );

  spi_sck_engine #(.DIV_WIDTH(12), .CNT_WIDTH(6)) u_dut12 (
    .clk_i(clk), .rst_i(rst), .en_i(en), .start_i(start12), .cpol_i(cpol), .cpha_i(cpha),
    .div_i(div12), .nbits_i(nbits), .busy_o(busy12), .done_o(done12), .sck_o(sck12),
    .lead_o(lead12), .trail_o(trail12), .shift_o(shift12), .sample_o(sample12),
    .bit_cnt_o(bit_cnt12)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [12:0] outs();
    return {busy, done, sck, lead, trail, shift, sample, bit_cnt};
  endfunction

  // Expected outputs t cycles after the accepting cycle: edge k sits at t = 1 + k*(d+1).
  function automatic logic [12:0] model(input int t, input int d, input int n,
                                        input bit pol, input bit pha);
    int  p, tend, k, bc;
    bit  at_edge, b, dn, s, l, tr, sh, sa;
    p    = d + 1;
    tend = 2 * n * p + 1;
    if (n == 0) return {1'b0, (t == 1), pol, 4'b0, 6'd0};
    k = (t - 1) / p;
    if (k > 2 * n) k = 2 * n;
    at_edge = (k >= 1) && ((t - 1) == k * p);
    b  = (t < tend);
    dn = (t == tend);
    s  = pol ^ k[0];
    l  = at_edge && k[0];
    tr = at_edge && !k[0];
    sa = pha ? tr : l;
    sh = pha ? l : ((t == 1) || (tr && k != 2 * n));
    bc = pha ? k / 2 : (k + 1) / 2;
    return {b, dn, s, l, tr, sh, sa, 6'(bc)};
  endfunction

  // One transfer, compared every cycle up to done; optionally scrambles inputs and pulses start mid-flight.
  task automatic run_transfer(input int d, input int n, input bit pol, input bit pha,
                              input bit scramble);
    int tend;
    div = 8'(d); nbits = 6'(n); cpol = pol; cpha = pha; start = 1'b1;
    step();
    start = 1'b0;
    tend = (n == 0) ? 1 : 2 * n * (d + 1) + 1;
    for (int t = 1; t <= tend; t++) begin
      if (t > 1) step();
      check($sformatf("xfer d=%0d n=%0d pol=%0d pha=%0d t=%0d", d, n, pol, pha, t),
            32'(outs()), 32'(model(t, d, n, pol, pha)));
      if (scramble && t < tend - 1) begin
        div   = 8'($urandom);
        nbits = 6'($urandom);
        cpol  = 1'($urandom);
        cpha  = 1'($urandom);
        start = 1'($urandom_range(0, 1));
      end else begin
        start = 1'b0;
      end
    end
    start = 1'b0;
    cpol  = pol;
    step();
  endtask

  typedef struct {
    int d; int n; bit pol; bit pha;
    int done_t; int n_samp; int n_shift; int n_busy; bit sck_end;
  } vec_t;

  initial begin
    vec_t vecs[6];
    int   done_t, n_samp, n_shift, n_busy, n_done, lead_t, trail_t;
    bit   sck_end;

    rst = 1'b1; en = 1'b1; start = 1'b0; cpol = 1'b1; cpha = 1'b0;
    div = '0; nbits = '0; start12 = 1'b0; div12 = '0;
    #12;
    check("reset outputs", 32'(outs()), 32'd0);
    step();
    rst = 1'b0;
    step();
    check("idle sck follows cpol", 32'(sck), 32'd1);

    // Test-plan vectors plus maximum divider and maximum bit count.
    vecs[0] = '{0,   8,  1'b0, 1'b0,  17, 8,  8,  16,  1'b0};
    vecs[1] = '{3,   4,  1'b1, 1'b1,  33, 4,  4,  32,  1'b1};
    vecs[2] = '{0,   0,  1'b1, 1'b0,  1,  0,  0,  0,   1'b1};
    vecs[3] = '{1,   3,  1'b0, 1'b1,  13, 3,  3,  12,  1'b0};
    vecs[4] = '{255, 1,  1'b1, 1'b0,  513, 1, 1,  512, 1'b1};
    vecs[5] = '{0,   63, 1'b0, 1'b0,  127, 63, 63, 126, 1'b0};
    foreach (vecs[i]) begin
      div = 8'(vecs[i].d); nbits = 6'(vecs[i].n); cpol = vecs[i].pol; cpha = vecs[i].pha;
      start = 1'b1;
      step();
      start = 1'b0;
      done_t = -1; n_samp = 0; n_shift = 0; n_busy = 0; sck_end = 1'b0;
      for (int t = 1; t <= 2000; t++) begin
        n_samp  += int'(sample);
        n_shift += int'(shift);
        n_busy  += int'(busy);
        if (done) begin
          done_t  = t;
          sck_end = sck;
          break;
        end
        step();
      end
      check($sformatf("vec%0d done cycle", i), 32'(done_t), 32'(vecs[i].done_t));
      check($sformatf("vec%0d samples", i), 32'(n_samp), 32'(vecs[i].n_samp));
      check($sformatf("vec%0d shifts", i), 32'(n_shift), 32'(vecs[i].n_shift));
      check($sformatf("vec%0d busy cycles", i), 32'(n_busy), 32'(vecs[i].n_busy));
      check($sformatf("vec%0d final sck", i), 32'(sck_end), 32'(vecs[i].sck_end));
      check($sformatf("vec%0d bit_cnt", i), 32'(bit_cnt), 32'(vecs[i].n));
      step();
    end

    // Abort: en_i low in cycle S+20 with div=2, nbits=16.
    div = 8'd2; nbits = 6'd16; cpol = 1'b0; cpha = 1'b0; start = 1'b1;
    step();
    start = 1'b0;
    for (int t = 2; t <= 20; t++) step();
    en = 1'b0; cpol = 1'b1;
    step();
    check("abort sck to cpol_i", 32'(sck), 32'd1);
    check("abort busy low", 32'(busy), 32'd0);
    check("abort strobes low", 32'({lead, trail, shift, sample}), 32'd0);
    check("abort bit_cnt held", 32'(bit_cnt), 32'd3);
    start = 1'b1;
    n_done = 0; n_busy = 0;
    for (int t = 0; t < 30; t++) begin
      step();
      start = 1'b0;
      n_done += int'(done);
      n_busy += int'(busy);
    end
    check("abort no done", 32'(n_done), 32'd0);
    check("start without en ignored", 32'(n_busy), 32'd0);
    check("abort bit_cnt still held", 32'(bit_cnt), 32'd3);
    en = 1'b1;
    run_transfer(2, 16, 1'b0, 1'b0, 1'b0);

    // Mid-transfer input changes and start pulses, then asynchronous reset mid-flight.
    div = 8'd1; nbits = 6'd5; cpol = 1'b0; cpha = 1'b1; start = 1'b1;
    step();
    start = 1'b0;
    for (int t = 1; t <= 9; t++) begin
      if (t > 1) step();
      check($sformatf("midchange t=%0d", t), 32'(outs()), 32'(model(t, 1, 5, 1'b0, 1'b1)));
      if (t == 3) begin
        div = 8'd7; nbits = 6'd2; cpol = 1'b1; cpha = 1'b0; start = 1'b1;
      end else begin
        start = 1'b0;
      end
    end
    #2 rst = 1'b1;
    #1;
    check("async reset mid-transfer", 32'(outs()), 32'd0);
    step();
    check("reset holds, no done", 32'(outs()), 32'd0);
    rst = 1'b0;
    cpol = 1'b1;
    step();
    check("post-reset sck follows cpol", 32'(sck), 32'd1);
    run_transfer(0, 8, 1'b0, 1'b0, 1'b0);

    // Randomized transfers, half of them with inputs scrambled mid-flight.
    for (int i = 0; i < 24; i++) begin
      run_transfer($urandom_range(0, 5), $urandom_range(0, 12), 1'($urandom), 1'($urandom),
                   1'($urandom_range(0, 1)));
    end

    // Widest divider of a 12-bit instance: half period of 4096 cycles.
    div12 = 12'hFFF; nbits = 6'd1; cpol = 1'b0; cpha = 1'b0; start12 = 1'b1;
    step();
    start12 = 1'b0;
    lead_t = -1; trail_t = -1; done_t = -1; sck_end = 1'b1;
    for (int t = 1; t <= 8400; t++) begin
      if (lead12 && lead_t < 0) lead_t = t;
      if (trail12 && trail_t < 0) trail_t = t;
      if (done12) begin
        done_t  = t;
        sck_end = sck12;
        break;
      end
      step();
    end
    check("div4095 leading edge", 32'(lead_t), 32'd4097);
    check("div4095 trailing edge", 32'(trail_t), 32'd8193);
    check("div4095 done", 32'(done_t), 32'd8193);
    check("div4095 final sck", 32'(sck_end), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
